// File: rtl/cla_add_ctrl.sv
// cla_add_ctrl: valid/ready front-end for an external registered 32-bit
// carry-lookahead adder. A narrow op uses one adder pass. A wide op uses two
// passes: the low word first, then the high word with the low carry-out.
// The result is held on rsp_* until the consumer takes it.
// Optional feature macro: CLA_ADD_CTRL_OVF_EN adds a registered signed-overflow
// output rsp_ovf.
module cla_add_ctrl #(
  parameter int ADD_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wide,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        req_ci,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ci,
  input  logic [31:0] add_s,
  input  logic        add_co,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_sum,
  output logic        rsp_co
`ifdef CLA_ADD_CTRL_OVF_EN
  ,
  output logic        rsp_ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter value seen just before the edge that samples the adder result.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADD_LAT - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_a_r;
  logic [31:0]      hi_b_r;
  logic             wide_r;
  logic [31:0]      sum_lo_r;

  // Two's-complement overflow: equal operand signs but a different result sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Sequencer: accept a request, drive the adder, wait out its latency,
  // capture the result and hold it until the consumer handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      hi_a_r    <= 32'h0;
      hi_b_r    <= 32'h0;
      wide_r    <= 1'b0;
      sum_lo_r  <= 32'h0;
      req_ready <= 1'b0;
      add_a     <= 32'h0;
      add_b     <= 32'h0;
      add_ci    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= 64'h0;
      rsp_co    <= 1'b0;
`ifdef CLA_ADD_CTRL_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // req_ready is 0 only on the first cycle after reset release.
          if (req_valid && req_ready) begin
            hi_a_r    <= req_a[63:32];
            hi_b_r    <= req_b[63:32];
            wide_r    <= req_wide;
            add_a     <= req_a[31:0];
            add_b     <= req_b[31:0];
            add_ci    <= req_ci;
            cnt_r     <= '0;
            req_ready <= 1'b0;
            state_r   <= LO;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LO: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            sum_lo_r <= add_s;
            if (wide_r) begin
              // Second pass: high words, chained through the low carry-out.
              add_a   <= hi_a_r;
              add_b   <= hi_b_r;
              add_ci  <= add_co;
              cnt_r   <= '0;
              state_r <= HI;
            end else begin
              rsp_sum   <= {32'h0, add_s};
              rsp_co    <= add_co;
              rsp_valid <= 1'b1;
`ifdef CLA_ADD_CTRL_OVF_EN
              // add_a/add_b still hold the low operand words here.
              rsp_ovf   <= signed_ovf(add_a[31], add_b[31], add_s[31]);
`endif
              state_r   <= DONE;
            end
          end else begin
            state_r <= LO;
          end
        end
        HI: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            rsp_sum   <= {add_s, sum_lo_r};
            rsp_co    <= add_co;
            rsp_valid <= 1'b1;
`ifdef CLA_ADD_CTRL_OVF_EN
            // add_a/add_b hold the high operand words; bit 31 is bit 63.
            rsp_ovf   <= signed_ovf(add_a[31], add_b[31], add_s[31]);
`endif
            state_r   <= DONE;
          end else begin
            state_r <= HI;
          end
        end
        DONE: begin
          // Requests are ignored here; only one op is ever in flight.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_add_ctrl.sv
// tb_cla_add_ctrl: self-checking bench for cla_add_ctrl. It hosts a registered
// adder model, applies a table of directed vectors, random ops checked against
// a plain-arithmetic reference, and hand-written backpressure/reset sequences.
module tb_cla_add_ctrl;

  localparam int ADD_LAT = 3;
  localparam int MAX_WAIT = 40;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wide;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_ci;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_s;
  logic        add_co;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_sum;
  logic        rsp_co;
`ifdef CLA_ADD_CTRL_OVF_EN
  logic        rsp_ovf;
`endif

  int total;
  int bad;

  cla_add_ctrl #(.ADD_LAT(ADD_LAT), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wide  (req_wide),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co)
`ifdef CLA_ADD_CTRL_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered adder with ADD_LAT-1 = 2 stages: a result is sampled ADD_LAT
  // edges after its operands change.
  logic [32:0] pipe1;
  logic [32:0] pipe2;
  always_ff @(posedge clk) begin
    pipe1 <= {1'b0, add_a} + {1'b0, add_b} + {32'h0, add_ci};
    pipe2 <= pipe1;
  end
  assign add_s  = pipe2[31:0];
  assign add_co = pipe2[32];

  typedef struct {
    logic        wide;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] exp_sum;
    logic        exp_co;
    logic        exp_ovf;
    int          hold;
    logic        pulse;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from the arithmetic definition.
  task automatic ref_add(input logic wide, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, output logic [63:0] sum, output logic co,
                         output logic ovf);
    logic [64:0] t;
    if (wide) begin
      t   = {1'b0, a} + {1'b0, b} + {64'h0, ci};
      sum = t[63:0];
      co  = t[64];
      ovf = (a[63] == b[63]) && (sum[63] != a[63]);
    end else begin
      t   = {33'h0, a[31:0]} + {33'h0, b[31:0]} + {64'h0, ci};
      sum = {32'h0, t[31:0]};
      co  = t[32];
      ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   n;
    logic [32:0] lo;
    lo = {1'b0, v.a[31:0]} + {1'b0, v.b[31:0]} + {32'h0, v.ci};
    @(negedge clk);
    chk("req_ready_before", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1;
    req_wide  = v.wide;
    req_a     = v.a;
    req_b     = v.b;
    req_ci    = v.ci;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_drop", {63'h0, req_ready}, 64'h0);
    n = 0;
    while (!rsp_valid && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
      if (v.wide && n == ADD_LAT) chk("hi_add_ci", {63'h0, add_ci}, {63'h0, lo[32]});
    end
    chk("latency", 64'(n), v.wide ? 64'(2 * ADD_LAT) : 64'(ADD_LAT));
    chk("rsp_sum", rsp_sum, v.exp_sum);
    chk("rsp_co", {63'h0, rsp_co}, {63'h0, v.exp_co});
`ifdef CLA_ADD_CTRL_OVF_EN
    chk("rsp_ovf", {63'h0, rsp_ovf}, {63'h0, v.exp_ovf});
`endif
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (v.pulse && i == 1) begin
        req_valid = 1'b1;
        req_a     = 64'h5;
        req_b     = 64'h5;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("hold_valid", {63'h0, rsp_valid}, 64'h1);
      chk("hold_sum", rsp_sum, v.exp_sum);
      chk("hold_co", {63'h0, rsp_co}, {63'h0, v.exp_co});
      chk("hold_req_ready", {63'h0, req_ready}, 64'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rel_req_ready", {63'h0, req_ready}, 64'h1);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (v.pulse) begin
      @(posedge clk); #1;
      chk("pulse_not_taken", {63'h0, req_ready}, 64'h1);
    end
  endtask

  initial begin
    vec_t v;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_wide  = 1'b0;
    req_a     = 64'h0;
    req_b     = 64'h0;
    req_ci    = 1'b0;
    rsp_ready = 1'b0;

    vecs[0] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b0, 64'h0000_FFFF, 64'hFFFF_0000, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 5, 1'b1};
    vecs[2] = '{1'b0, 64'h135F_A562, 64'h3561_4642, 1'b0, 64'h48C0_EBA4, 1'b0, 1'b0, 1, 1'b0};
    vecs[3] = '{1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 2, 1'b0};
    vecs[5] = '{1'b0, 64'h7FFF_FFFF, 64'h1, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 0, 1'b0};
    vecs[6] = '{1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0, 1'b0};
    vecs[7] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 1'b0};

    // Reset state.
    #1;
    chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_rsp_sum", rsp_sum, 64'h0);
    chk("rst_add_a", {32'h0, add_a}, 64'h0);
    chk("rst_add_ci", {63'h0, add_ci}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_ready", {63'h0, req_ready}, 64'h1);

    // Directed table.
    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Random ops against the reference.
    for (int i = 0; i < 30; i++) begin
      v.wide  = 1'($urandom_range(0, 1));
      v.a     = {$urandom, $urandom};
      v.b     = {$urandom, $urandom};
      if (i % 7 == 3) v.b = ~v.a;
      v.ci    = 1'($urandom_range(0, 1));
      v.hold  = $urandom_range(0, 2);
      v.pulse = 1'b0;
      ref_add(v.wide, v.a, v.b, v.ci, v.exp_sum, v.exp_co, v.exp_ovf);
      run_op(v);
    end

    // Reset during the HI pass of a wide op.
    @(negedge clk);
    req_valid = 1'b1;
    req_wide  = 1'b1;
    req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b     = 64'h1234_5678_9ABC_DEF0;
    req_ci    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (ADD_LAT + 1) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("mid_rst_add_a", {32'h0, add_a}, 64'h0);
    chk("mid_rst_add_b", {32'h0, add_b}, 64'h0);
    chk("mid_rst_add_ci", {63'h0, add_ci}, 64'h0);
    chk("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("mid_rst_rsp_sum", rsp_sum, 64'h0);
    chk("mid_rst_rsp_co", {63'h0, rsp_co}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {63'h0, req_ready}, 64'h1);
    for (int i = 0; i < 2 * ADD_LAT + 2; i++) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", {63'h0, rsp_valid}, 64'h0);
    end
    v = '{1'b0, 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 0, 1'b0};
    run_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
